// File: rtl/bird_physics_fsm.sv
// Bird vertical physics and life-cycle FSM for a flappy-style game.
// Gravity/flap integration at a divided tick rate, with collision, death fall and a scan-out pixel test.
module bird_physics_fsm #(
    parameter int XMAX     = 800,
    parameter int YMAX     = 525,
    parameter int X_POS    = 160,
    parameter int BIRD_W   = 16,
    parameter int BIRD_H   = 16,
    parameter int Y_INIT   = 200,
    parameter int Y_TOP    = 0,
    parameter int Y_BOT    = 480,
    parameter int TICK_DIV = 1250000,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = 6,
    parameter int VMAX     = 4
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic [$clog2(XMAX)-1:0]   i_X_Count,
    input  logic [$clog2(YMAX)-1:0]   i_Y_Count,
    input  logic                      i_Start,
    input  logic                      i_Flap,
    input  logic                      i_Pipe_Hit,
    output logic                      o_Draw_Bird,
    output logic                      o_Dead,
    output logic                      o_Playing,
    output logic [$clog2(YMAX)-1:0]   o_Y_Pos
);

    localparam int unsigned XW = $clog2(XMAX);
    localparam int unsigned YW = $clog2(YMAX);
    localparam int unsigned VW = $clog2(FLAP_VEL + VMAX) + 2;
    localparam int unsigned PW = YW + 2;
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0]        TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [YW-1:0]        Y_START   = YW'(Y_INIT);
    localparam logic [YW-1:0]        Y_CEIL    = YW'(Y_TOP + 1);
    localparam logic [YW-1:0]        Y_FLOOR   = YW'(Y_BOT - BIRD_H);
    localparam logic signed [PW-1:0] TOP_S     = PW'(Y_TOP);
    localparam logic signed [PW-1:0] BOT_S     = PW'(Y_BOT);
    localparam logic signed [PW-1:0] FLOOR_S   = PW'(Y_BOT - BIRD_H);
    localparam logic signed [PW-1:0] BH_S      = PW'(BIRD_H);
    localparam logic signed [PW-1:0] VMAX_S    = PW'(VMAX);
    localparam logic signed [VW-1:0] GRAV_V    = VW'(GRAVITY);
    localparam logic signed [VW-1:0] VMAX_V    = VW'(VMAX);
    localparam logic signed [VW-1:0] FLAP_V    = VW'(-FLAP_VEL);
    localparam logic [XW-1:0]        X_LO      = XW'(X_POS);
    localparam logic [XW-1:0]        X_HI      = XW'(X_POS + BIRD_W);
    localparam logic [YW:0]          BH_Y      = (YW+1)'(BIRD_H);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        DYING  = 2'd2,
        DEAD   = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [YW-1:0]         y, y_next;
    logic signed [VW-1:0]  vel, vel_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic                  pend, pend_next;
    logic                  start_prev, flap_prev;
    logic                  dead, dead_next;
    logic                  playing, playing_next;

    logic                  start_edge, flap_edge, run, tick;
    logic signed [VW-1:0]  vel_inc, vel_fall, vel_tick;
    logic signed [PW-1:0]  y_s, y_fly, y_drop;

    // State and datapath registers
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state      <= IDLE;
            y          <= Y_START;
            vel        <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            start_prev <= 1'b0;
            flap_prev  <= 1'b0;
            dead       <= 1'b0;
            playing    <= 1'b0;
        end else begin
            state      <= state_next;
            y          <= y_next;
            vel        <= vel_next;
            cnt        <= cnt_next;
            pend       <= pend_next;
            start_prev <= i_Start;
            flap_prev  <= i_Flap;
            dead       <= dead_next;
            playing    <= playing_next;
        end
    end

    // Next-state, physics step and output decode
    always_comb begin
        state_next   = state;
        y_next       = y;
        vel_next     = vel;
        pend_next    = pend;
        cnt_next     = '0;
        dead_next    = 1'b0;
        playing_next = 1'b0;

        start_edge = i_Start & ~start_prev;
        flap_edge  = i_Flap & ~flap_prev;
        run        = (state == FLYING) || (state == DYING);
        tick       = run && (cnt == TICK_LAST);
        if (run) begin
            cnt_next = tick ? '0 : cnt + CW'(1);
        end

        vel_inc  = vel + GRAV_V;
        vel_fall = (vel_inc > VMAX_V) ? VMAX_V : vel_inc;
        vel_tick = (pend || flap_edge) ? FLAP_V : vel_fall;
        y_s      = signed'({2'b00, y});
        y_fly    = y_s + {{(PW-VW){vel_tick[VW-1]}}, vel_tick};
        y_drop   = y_s + VMAX_S;

        case (state)
            IDLE: begin
                y_next    = Y_START;
                vel_next  = '0;
                pend_next = 1'b0;
                if (start_edge) state_next = FLYING;
            end
            FLYING: begin
                // Pipe collision freezes the bird even on a tick cycle
                if (i_Pipe_Hit) begin
                    state_next = DYING;
                    vel_next   = VMAX_V;
                    pend_next  = 1'b0;
                end else if (tick) begin
                    pend_next = 1'b0;
                    vel_next  = vel_tick;
                    if (y_fly <= TOP_S) begin
                        y_next     = Y_CEIL;
                        vel_next   = VMAX_V;
                        state_next = DYING;
                    end else if (y_fly + BH_S >= BOT_S) begin
                        y_next     = Y_FLOOR;
                        vel_next   = VMAX_V;
                        state_next = DYING;
                    end else begin
                        y_next = y_fly[YW-1:0];
                    end
                end else begin
                    pend_next = pend | flap_edge;
                end
            end
            DYING: begin
                vel_next  = VMAX_V;
                pend_next = 1'b0;
                if (y == Y_FLOOR) begin
                    state_next = DEAD;
                end else if (tick) begin
                    y_next = (y_drop >= FLOOR_S) ? Y_FLOOR : y_drop[YW-1:0];
                end
            end
            DEAD: begin
                if (start_edge) begin
                    state_next = IDLE;
                    y_next     = Y_START;
                    vel_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        dead_next    = (state_next == DEAD) && (state != DEAD);
        playing_next = (state_next == FLYING);
    end

    assign o_Dead    = dead;
    assign o_Playing = playing;
    assign o_Y_Pos   = y;

    // Zero-latency sprite hit test against the live scan position
    assign o_Draw_Bird = (i_X_Count >= X_LO) && (i_X_Count < X_HI) &&
                         (i_Y_Count >= y) &&
                         ({1'b0, i_Y_Count} < ({1'b0, y} + BH_Y));

endmodule

// File: tb/tb_bird_physics_fsm.sv
// Randomised scoreboard bench for bird_physics_fsm with an integer reference model.
module tb_bird_physics_fsm;

    localparam int TD = 4;
    localparam int M_IDLE = 0, M_FLY = 1, M_DYING = 2, M_DEAD = 3;

    typedef struct {
        int y;
        bit dead;
        bit play;
        bit draw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start, flap, pipe;
    logic [9:0] xc, yc;
    logic       draw, dead, playing;
    logic [9:0] ypos;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int ms, my, mv, mc, mp, msp, mfp;

    always #5 clk = ~clk;

    bird_physics_fsm #(.TICK_DIV(TD)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_X_Count(xc), .i_Y_Count(yc),
        .i_Start(start), .i_Flap(flap), .i_Pipe_Hit(pipe),
        .o_Draw_Bird(draw), .o_Dead(dead), .o_Playing(playing), .o_Y_Pos(ypos)
    );

    // Reference: game rules applied once per clock with plain integers
    task automatic model_step(input bit r, input bit s, input bit f, input bit p, output bit d);
        int old, se, fe, tk, v, yn;
        old = ms;
        if (r) begin
            ms = M_IDLE; my = 200; mv = 0; mc = 0; mp = 0; msp = 0; mfp = 0;
            d = 0;
        end else begin
            se = s && !msp;
            fe = f && !mfp;
            tk = (old == M_FLY || old == M_DYING) && mc == TD - 1;
            mc = (old == M_FLY || old == M_DYING) ? (mc + 1) % TD : 0;
            case (old)
                M_IDLE: begin
                    my = 200; mv = 0; mp = 0;
                    if (se) ms = M_FLY;
                end
                M_FLY: begin
                    if (p) begin
                        ms = M_DYING; mp = 0;
                    end else if (tk) begin
                        v = (mp || fe) ? -6 : ((mv + 1 > 4) ? 4 : mv + 1);
                        mv = v; mp = 0;
                        yn = my + v;
                        if (yn <= 0) begin my = 1; ms = M_DYING; end
                        else if (yn + 16 >= 480) begin my = 464; ms = M_DYING; end
                        else my = yn;
                    end else if (fe) begin
                        mp = 1;
                    end
                end
                M_DYING: begin
                    if (my == 464) ms = M_DEAD;
                    else if (tk) my = (my + 4 > 464) ? 464 : my + 4;
                end
                default: begin
                    if (se) begin ms = M_IDLE; my = 200; mv = 0; end
                end
            endcase
            d = (ms == M_DEAD) && (old != M_DEAD);
            msp = s; mfp = f;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit f, input bit p, input int x, input int yv);
        exp_t e;
        bit   d;
        @(negedge clk);
        rst = r; start = s; flap = f; pipe = p;
        xc = 10'(x); yc = 10'(yv);
        model_step(r, s, f, p, d);
        e.y    = my;
        e.dead = d;
        e.play = (ms == M_FLY);
        e.draw = (x >= 160) && (x < 176) && (yv >= my) && (yv < my + 16);
        q.push_back(e);
    endtask

    task automatic run(input int n, input bit s, input bit f, input bit p);
        int lo;
        for (int i = 0; i < n; i++) begin
            lo = (my > 4) ? my - 4 : 0;
            cyc(1'b0, s, f, p, int'($urandom_range(150, 185)), int'($urandom_range(lo, my + 20)));
        end
    endtask

    // Monitor: every clock the DUT presents a fresh output set
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (ypos !== 10'(e.y)) begin
                    miscompares++;
                    $display("FAIL y_pos t=%0t got %0d want %0d", $time, ypos, e.y);
                end
                if (dead !== e.dead) begin
                    miscompares++;
                    $display("FAIL dead t=%0t got %b want %b", $time, dead, e.dead);
                end
                if (playing !== e.play) begin
                    miscompares++;
                    $display("FAIL playing t=%0t got %b want %b", $time, playing, e.play);
                end
                if (draw !== e.draw) begin
                    miscompares++;
                    $display("FAIL draw t=%0t x=%0d y=%0d got %b want %b", $time, xc, yc, draw, e.draw);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; flap = 1'b0; pipe = 1'b0; xc = '0; yc = '0;
        ms = M_IDLE; my = 200; mv = 0; mc = 0; mp = 0; msp = 0; mfp = 0;

        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 160, 200);
        // Sprite boundary points at the idle height
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 160, 200);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 175, 215);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 176, 200);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 160, 216);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 159, 200);

        // Free fall for five ticks, then one flap with the level held
        run(1, 1'b1, 1'b0, 1'b0);
        run(20, 1'b0, 1'b0, 1'b0);
        run(12, 1'b0, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b1);
        run(300, 1'b0, 1'b0, 1'b0);

        // Start in DEAD returns to IDLE only; second start flies
        run(1, 1'b1, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            run(2, 1'b0, 1'b1, 1'b0);
            run(2, 1'b0, 1'b0, 1'b0);
        end
        run(500, 1'b0, 1'b0, 1'b0);

        // Reset while flying
        run(1, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0);
        run(30, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 165, 205);
        run(4, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0)
                cyc(1'b1, 1'b0, 1'b0, 1'b0, 160, 200);
            else
                run(1, $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 199) == 0);
        end

        repeat (2) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
